// File: rtl/fetch_if.sv
// Fetch-stage bus: hazard/redirect controls, instruction-memory port and IF/ID register outputs.
interface fetch_if;
    logic        Stall;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic [31:0] IMAddr;
    logic [31:0] IMData;
    logic [31:0] IFID_Instr;
    logic [31:0] IFID_PCPlus4;
    logic        IFID_Valid;
    logic        Misaligned;

    modport master (
        input  Stall, Redirect, RedirectPC, IMData,
        output IMAddr, IFID_Instr, IFID_PCPlus4, IFID_Valid, Misaligned
    );

    modport slave (
        output Stall, Redirect, RedirectPC, IMData,
        input  IMAddr, IFID_Instr, IFID_PCPlus4, IFID_Valid, Misaligned
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register, sticky misaligned-redirect flag.
// Optional performance counters are enabled with the FETCH_PERF_CNT_EN macro.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    fetch_if.master     bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] FetchCount,
    output logic [31:0] StallCount,
    output logic [31:0] FlushCount
`endif
);

    localparam int unsigned XLEN = 32;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
    logic            valid_q, valid_d;
    logic            misaligned_q, misaligned_d;
    logic [XLEN-1:0] pc_inc;
    logic            advance;

    assign pc_inc  = pc_q + XLEN'(4);
    assign advance = !bus.Redirect && !bus.Stall;

    // Next-state: redirect flushes IF/ID, stall holds everything, otherwise advance.
    always_comb begin
        pc_d         = pc_q;
        instr_d      = instr_q;
        pc_plus4_d   = pc_plus4_q;
        valid_d      = valid_q;
        misaligned_d = misaligned_q;
        if (bus.Redirect) begin
            pc_d       = {bus.RedirectPC[XLEN-1:2], 2'b00};
            instr_d    = '0;
            pc_plus4_d = '0;
            valid_d    = 1'b0;
            if (bus.RedirectPC[1:0] != 2'b00) begin
                misaligned_d = 1'b1;
            end
        end else if (!bus.Stall) begin
            pc_d       = pc_inc;
            instr_d    = bus.IMData;
            pc_plus4_d = pc_inc;
            valid_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            instr_q      <= '0;
            pc_plus4_q   <= '0;
            valid_q      <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            pc_plus4_q   <= pc_plus4_d;
            valid_q      <= valid_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign bus.IMAddr       = pc_q;
    assign bus.IFID_Instr   = instr_q;
    assign bus.IFID_PCPlus4 = pc_plus4_q;
    assign bus.IFID_Valid   = valid_q;
    assign bus.Misaligned   = misaligned_q;

`ifdef FETCH_PERF_CNT_EN
    logic [XLEN-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [XLEN-1:0] stall_cnt_q, stall_cnt_d;
    logic [XLEN-1:0] flush_cnt_q, flush_cnt_d;

    // Each cycle falls into exactly one of advance, stall-only or redirect.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (bus.Redirect) begin
            flush_cnt_d = flush_cnt_q + XLEN'(1);
        end else if (bus.Stall) begin
            stall_cnt_d = stall_cnt_q + XLEN'(1);
        end else begin
            fetch_cnt_d = fetch_cnt_q + XLEN'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign FetchCount = fetch_cnt_q;
    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;
`else
    logic unused_advance;
    assign unused_advance = advance;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage: startup, stall, redirect, wrap, misaligned and reset cases.
module tb_fetch_stage;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    fetch_if bus ();
    fetch_if bus_w ();

    // Instruction memory model: two fixed words, every other address returns a tagged word.
    function automatic logic [31:0] im_word(input logic [31:0] addr);
        if (addr == 32'h0000_0000) return 32'h8C03_0000;
        if (addr == 32'h0000_0004) return 32'h8C04_0001;
        return 32'h1000_0000 | addr;
    endfunction

    assign bus.IMData   = im_word(bus.IMAddr);
    assign bus_w.IMData = im_word(bus_w.IMAddr);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count, stall_count, flush_count;
    logic [31:0] fetch_count_w, stall_count_w, flush_count_w;
`endif

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef FETCH_PERF_CNT_EN
        ,
        .FetchCount (fetch_count),
        .StallCount (stall_count),
        .FlushCount (flush_count)
`endif
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk (clk),
        .rst (rst),
        .bus (bus_w)
`ifdef FETCH_PERF_CNT_EN
        ,
        .FetchCount (fetch_count_w),
        .StallCount (stall_count_w),
        .FlushCount (flush_count_w)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] instr,
                            input logic [31:0] pc4, input logic valid,
                            input logic [31:0] addr);
        chk({tag, "_instr"}, bus.IFID_Instr, instr);
        chk({tag, "_pc4"}, bus.IFID_PCPlus4, pc4);
        chk({tag, "_valid"}, 32'(bus.IFID_Valid), 32'(valid));
        chk({tag, "_imaddr"}, bus.IMAddr, addr);
    endtask

    initial begin
        rst              = 1'b1;
        bus.Stall        = 1'b0;
        bus.Redirect     = 1'b0;
        bus.RedirectPC   = '0;
        bus_w.Stall      = 1'b0;
        bus_w.Redirect   = 1'b0;
        bus_w.RedirectPC = '0;

        step();
        step();
        chk_ifid("reset", 32'h0, 32'h0, 1'b0, 32'h0);
        chk("reset_mis", 32'(bus.Misaligned), 32'h0);
        chk("wrap_addr0", bus_w.IMAddr, 32'hFFFF_FFF8);
`ifdef FETCH_PERF_CNT_EN
        chk("reset_fetchcnt", fetch_count, 32'h0);
`endif

        // First instructions after reset release
        rst = 1'b0;
        step();
        chk_ifid("cyc1", 32'h8C03_0000, 32'h4, 1'b1, 32'h4);
        chk("wrap_addr1", bus_w.IMAddr, 32'hFFFF_FFFC);
        chk("wrap_pc4_1", bus_w.IFID_PCPlus4, 32'hFFFF_FFFC);
        step();
        chk_ifid("cyc2", 32'h8C04_0001, 32'h8, 1'b1, 32'h8);
        chk("wrap_addr2", bus_w.IMAddr, 32'h0000_0000);
        chk("wrap_pc4_2", bus_w.IFID_PCPlus4, 32'h0000_0000);
        step();
        chk_ifid("cyc3", 32'h1000_0008, 32'hC, 1'b1, 32'hC);

        // Stall three cycles at PC=12
        bus.Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_ifid("stall", 32'h1000_0008, 32'hC, 1'b1, 32'hC);
        end
`ifdef FETCH_PERF_CNT_EN
        chk("stall_cnt", stall_count, 32'h3);
        chk("fetch_cnt", fetch_count, 32'h3);
`endif
        bus.Stall = 1'b0;
        step();
        chk_ifid("resume", 32'h1000_000C, 32'h10, 1'b1, 32'h10);

        // Redirect wins over stall
        bus.Stall      = 1'b1;
        bus.Redirect   = 1'b1;
        bus.RedirectPC = 32'h28;
        step();
        chk_ifid("redir", 32'h0, 32'h0, 1'b0, 32'h28);
        bus.Stall    = 1'b0;
        bus.Redirect = 1'b0;
        step();
        chk_ifid("after_redir", 32'h1000_0028, 32'h2C, 1'b1, 32'h2C);
        chk("mis_clean", 32'(bus.Misaligned), 32'h0);

        // Misaligned target, then back-to-back aligned redirects
        bus.Redirect   = 1'b1;
        bus.RedirectPC = 32'h26;
        step();
        chk("mis_addr", bus.IMAddr, 32'h24);
        chk("mis_set", 32'(bus.Misaligned), 32'h1);
        bus.RedirectPC = 32'h100;
        step();
        chk("b2b_addr1", bus.IMAddr, 32'h100);
        bus.RedirectPC = 32'h200;
        step();
        chk_ifid("b2b2", 32'h0, 32'h0, 1'b0, 32'h200);
        chk("mis_sticky", 32'(bus.Misaligned), 32'h1);
        bus.Redirect = 1'b0;
        step();
        chk_ifid("after_b2b", 32'h1000_0200, 32'h204, 1'b1, 32'h204);
`ifdef FETCH_PERF_CNT_EN
        chk("flush_cnt", flush_count, 32'h4);
`endif

        // Reset overrides stall and redirect mid-stream
        rst            = 1'b1;
        bus.Stall      = 1'b1;
        bus.Redirect   = 1'b1;
        bus.RedirectPC = 32'h80;
        step();
        chk_ifid("midrst", 32'h0, 32'h0, 1'b0, 32'h0);
        chk("midrst_mis", 32'(bus.Misaligned), 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("midrst_stallcnt", stall_count, 32'h0);
        chk("midrst_flushcnt", flush_count, 32'h0);
`endif
        rst          = 1'b0;
        bus.Stall    = 1'b0;
        bus.Redirect = 1'b0;
        step();
        chk_ifid("restart", 32'h8C03_0000, 32'h4, 1'b1, 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
